ctrl_pipeline: RTL and testbench

Parametrised pipelined control unit for the RV32I core. Decodes the ID-stage opcode into the EX/MEM/WB control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers with valid bits. Owns load-use hazard stalling (configurable bubble count), branch/jump flush and whole-pipe freeze on data-memory wait.

---
 rtl/ctrl_pipeline_if.sv | 36 +++
 rtl/ctrl_pipeline.sv | 195 +++++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipeline_if.sv
// ctrl_pipeline_if: ID-stage inputs and EX/MEM/WB control outputs of the
// pipelined control unit, bundled with the slave (unit) / master (driver) views.
interface ctrl_pipeline_if #(parameter int RA_W = 5);
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [RA_W-1:0] id_rd, id_rs1, id_rs2;
  logic            ex_redirect;
  logic            mem_ready;
  logic            if_stall;
  logic            ex_valid;
  logic [1:0]      ex_ula_op, ex_alu_src1, ex_alu_src2;
  logic            ex_branch, ex_jump, ex_jalr;
  logic            ex_mem_rd, ex_mem_wr, ex_reg_wr;
  logic [RA_W-1:0] ex_rd;
  logic            mem_valid, mem_rd, mem_wr, mem_reg_wr;
  logic [RA_W-1:0] mem_rd_addr;
  logic            wb_valid, wb_reg_wr, wb_mux;
  logic [RA_W-1:0] wb_rd;
  logic            illegal;

  modport slave (
    input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, ex_redirect, mem_ready,
    output if_stall, ex_valid, ex_ula_op, ex_alu_src1, ex_alu_src2,
           ex_branch, ex_jump, ex_jalr, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_rd,
           mem_valid, mem_rd, mem_wr, mem_reg_wr, mem_rd_addr,
           wb_valid, wb_reg_wr, wb_mux, wb_rd, illegal
  );

  modport master (
    output id_valid, id_opcode, id_rd, id_rs1, id_rs2, ex_redirect, mem_ready,
    input  if_stall, ex_valid, ex_ula_op, ex_alu_src1, ex_alu_src2,
           ex_branch, ex_jump, ex_jalr, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_rd,
           mem_valid, mem_rd, mem_wr, mem_reg_wr, mem_rd_addr,
           wb_valid, wb_reg_wr, wb_mux, wb_rd, illegal
  );
endinterface

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: RV32I control unit. Decodes the ID opcode into a control
// bundle and carries it through ID/EX, EX/MEM, MEM/WB with valid bits.
// Handles load-use stalls (LU_BUBBLES bubbles), branch/jump flush and a
// whole-pipe freeze while data memory is busy.
// Optional: define ILLEGAL_TRAP_EN for a sticky illegal-opcode flag.
module ctrl_pipeline #(
  parameter int RA_W       = 5,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  ctrl_pipeline_if.slave bus
);

  typedef struct packed {
    logic       reg_wr;
    logic       mux;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] ula_op;
    logic [1:0] src1;
    logic [1:0] src2;
    logic       branch;
    logic       jump;
    logic       jalr;
  } ctrl_t;

  ctrl_t           dec_c;
  logic            dec_legal, use_rs1, use_rs2;

  // ID/EX
  logic            ex_valid_q, ex_valid_d;
  ctrl_t           ex_c_q, ex_c_d;
  logic [RA_W-1:0] ex_rd_q, ex_rd_d;
  // EX/MEM
  logic            mem_valid_q, mem_valid_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic            mem_reg_wr_q, mem_reg_wr_d, mem_mux_q, mem_mux_d;
  logic [RA_W-1:0] mem_rda_q, mem_rda_d;
  // MEM/WB
  logic            wb_valid_q, wb_valid_d, wb_reg_wr_q, wb_reg_wr_d, wb_mux_q, wb_mux_d;
  logic [RA_W-1:0] wb_rd_q, wb_rd_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            freeze, hazard, stall;

  // Opcode decode; unknown opcodes decode to an all-zero bubble.
  always_comb begin
    dec_c     = '0;
    dec_legal = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (bus.id_opcode)
      7'b0110011: begin dec_c = ctrl_t'(13'b1000_10_00_00_000); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0010011: begin dec_c = ctrl_t'(13'b1000_10_00_01_000); use_rs1 = 1'b1; end
      7'b0000011: begin dec_c = ctrl_t'(13'b1110_00_00_01_000); use_rs1 = 1'b1; end
      7'b0100011: begin dec_c = ctrl_t'(13'b0001_00_00_01_000); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b1100011: begin dec_c = ctrl_t'(13'b0000_00_00_00_100); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0110111: dec_c = ctrl_t'(13'b1000_00_10_01_000);
      7'b0010111: dec_c = ctrl_t'(13'b1000_00_01_01_000);
      7'b1101111: dec_c = ctrl_t'(13'b1000_00_01_10_010);
      7'b1100111: begin dec_c = ctrl_t'(13'b1000_00_01_10_011); use_rs1 = 1'b1; end
      default:    dec_legal = 1'b0;
    endcase
    // x0 is never written
    if (bus.id_rd == '0) dec_c.reg_wr = 1'b0;
  end

  assign freeze = mem_valid_q & (mem_rd_q | mem_wr_q) & ~bus.mem_ready;
  assign hazard = ex_valid_q & ex_c_q.mem_rd & (ex_rd_q != '0) & bus.id_valid &
                  ((use_rs1 & (bus.id_rs1 == ex_rd_q)) | (use_rs2 & (bus.id_rs2 == ex_rd_q)));

  // Next state: freeze > flush > pending bubbles > load-use hazard > normal.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_c_d       = ex_c_q;
    ex_rd_d      = ex_rd_q;
    mem_valid_d  = mem_valid_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    mem_reg_wr_d = mem_reg_wr_q;
    mem_mux_d    = mem_mux_q;
    mem_rda_d    = mem_rda_q;
    wb_valid_d   = wb_valid_q;
    wb_reg_wr_d  = wb_reg_wr_q;
    wb_mux_d     = wb_mux_q;
    wb_rd_d      = wb_rd_q;
    cnt_d        = cnt_q;
    stall        = 1'b1;
    if (!freeze) begin
      stall        = 1'b0;
      mem_valid_d  = ex_valid_q;
      mem_rd_d     = ex_c_q.mem_rd;
      mem_wr_d     = ex_c_q.mem_wr;
      mem_reg_wr_d = ex_c_q.reg_wr;
      mem_mux_d    = ex_c_q.mux;
      mem_rda_d    = ex_rd_q;
      wb_valid_d   = mem_valid_q;
      wb_reg_wr_d  = mem_reg_wr_q;
      wb_mux_d     = mem_mux_q;
      wb_rd_d      = mem_rda_q;
      ex_valid_d   = 1'b0;
      ex_c_d       = '0;
      ex_rd_d      = '0;
      if (bus.ex_redirect) begin
        cnt_d = '0;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
        stall = 1'b1;
      end else if (hazard) begin
        cnt_d = CNT_W'(LU_BUBBLES - 1);
        stall = 1'b1;
      end else if (bus.id_valid && dec_legal) begin
        ex_valid_d = 1'b1;
        ex_c_d     = dec_c;
        ex_rd_d    = bus.id_rd;
      end
    end
  end

  // Stage registers and bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_c_q       <= '0;
      ex_rd_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_reg_wr_q <= 1'b0;
      mem_mux_q    <= 1'b0;
      mem_rda_q    <= '0;
      wb_valid_q   <= 1'b0;
      wb_reg_wr_q  <= 1'b0;
      wb_mux_q     <= 1'b0;
      wb_rd_q      <= '0;
      cnt_q        <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_c_q       <= ex_c_d;
      ex_rd_q      <= ex_rd_d;
      mem_valid_q  <= mem_valid_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_reg_wr_q <= mem_reg_wr_d;
      mem_mux_q    <= mem_mux_d;
      mem_rda_q    <= mem_rda_d;
      wb_valid_q   <= wb_valid_d;
      wb_reg_wr_q  <= wb_reg_wr_d;
      wb_mux_q     <= wb_mux_d;
      wb_rd_q      <= wb_rd_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic ill_q, ill_d;
  // Set only when an unknown valid opcode would actually have entered ID/EX.
  always_comb begin
    ill_d = ill_q | (bus.id_valid & ~dec_legal & ~freeze & ~bus.ex_redirect &
                     (cnt_q == '0) & ~hazard);
  end
  // Sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ill_q <= 1'b0;
    else        ill_q <= ill_d;
  end
  assign bus.illegal = ill_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.if_stall    = stall;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_ula_op   = ex_c_q.ula_op;
  assign bus.ex_alu_src1 = ex_c_q.src1;
  assign bus.ex_alu_src2 = ex_c_q.src2;
  assign bus.ex_branch   = ex_c_q.branch;
  assign bus.ex_jump     = ex_c_q.jump;
  assign bus.ex_jalr     = ex_c_q.jalr;
  assign bus.ex_mem_rd   = ex_c_q.mem_rd;
  assign bus.ex_mem_wr   = ex_c_q.mem_wr;
  assign bus.ex_reg_wr   = ex_c_q.reg_wr;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_reg_wr  = mem_reg_wr_q;
  assign bus.mem_rd_addr = mem_rda_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_reg_wr   = wb_reg_wr_q;
  assign bus.wb_mux      = wb_mux_q;
  assign bus.wb_rd       = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: drives two control units (1 and 3 load-use bubbles) with
// the same ID stream and checks every cycle against a slot-level model.
module tb_ctrl_pipeline;
  localparam int RA_W = 5;
`ifdef ILLEGAL_TRAP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipeline_if #(.RA_W(RA_W)) b1 ();
  ctrl_pipeline_if #(.RA_W(RA_W)) b3 ();

  ctrl_pipeline #(.RA_W(RA_W), .LU_BUBBLES(1), .CNT_W(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ctrl_pipeline #(.RA_W(RA_W), .LU_BUBBLES(3), .CNT_W(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  logic       i_v, i_redir, i_rdy;
  logic [6:0] i_op;
  logic [4:0] i_rd, i_rs1, i_rs2;

  assign b1.id_valid = i_v;   assign b3.id_valid = i_v;
  assign b1.id_opcode = i_op; assign b3.id_opcode = i_op;
  assign b1.id_rd = i_rd;     assign b3.id_rd = i_rd;
  assign b1.id_rs1 = i_rs1;   assign b3.id_rs1 = i_rs1;
  assign b1.id_rs2 = i_rs2;   assign b3.id_rs2 = i_rs2;
  assign b1.ex_redirect = i_redir; assign b3.ex_redirect = i_redir;
  assign b1.mem_ready = i_rdy;     assign b3.mem_ready = i_rdy;

  logic [17:0] oex [2];
  logic [8:0]  omem[2];
  logic [7:0]  owb [2];
  logic        ostl[2], oill[2];

  assign oex[0] = {b1.ex_valid, b1.ex_ula_op, b1.ex_alu_src1, b1.ex_alu_src2, b1.ex_branch,
                   b1.ex_jump, b1.ex_jalr, b1.ex_mem_rd, b1.ex_mem_wr, b1.ex_reg_wr, b1.ex_rd};
  assign oex[1] = {b3.ex_valid, b3.ex_ula_op, b3.ex_alu_src1, b3.ex_alu_src2, b3.ex_branch,
                   b3.ex_jump, b3.ex_jalr, b3.ex_mem_rd, b3.ex_mem_wr, b3.ex_reg_wr, b3.ex_rd};
  assign omem[0] = {b1.mem_valid, b1.mem_rd, b1.mem_wr, b1.mem_reg_wr, b1.mem_rd_addr};
  assign omem[1] = {b3.mem_valid, b3.mem_rd, b3.mem_wr, b3.mem_reg_wr, b3.mem_rd_addr};
  assign owb[0] = {b1.wb_valid, b1.wb_reg_wr, b1.wb_mux, b1.wb_rd};
  assign owb[1] = {b3.wb_valid, b3.wb_reg_wr, b3.wb_mux, b3.wb_rd};
  assign ostl[0] = b1.if_stall; assign ostl[1] = b3.if_stall;
  assign oill[0] = b1.illegal;  assign oill[1] = b3.illegal;

  // Model: one slot per stage holding the full decoded control word
  // c = {reg_wr, mux, mem_rd, mem_wr, ula[1:0], src1[1:0], src2[1:0], br, jmp, jalr}
  typedef struct packed {bit v; bit [12:0] c; bit [4:0] rd;} slot_t;
  slot_t ex_m[2], mem_m[2], wb_m[2];
  int    cnt_m[2], nstall[2];
  bit    ill_m[2];
  int    lub[2] = '{1, 3};

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mdec(input logic [6:0] op, output bit lg, output bit [12:0] c,
                               output bit u1, output bit u2);
    lg = 1'b1; u1 = 1'b0; u2 = 1'b0; c = '0;
    case (op)
      7'b0110011: begin c = 13'b1_0_0_0_10_00_00_0_0_0; u1 = 1; u2 = 1; end
      7'b0010011: begin c = 13'b1_0_0_0_10_00_01_0_0_0; u1 = 1; end
      7'b0000011: begin c = 13'b1_1_1_0_00_00_01_0_0_0; u1 = 1; end
      7'b0100011: begin c = 13'b0_0_0_1_00_00_01_0_0_0; u1 = 1; u2 = 1; end
      7'b1100011: begin c = 13'b0_0_0_0_00_00_00_1_0_0; u1 = 1; u2 = 1; end
      7'b0110111: c = 13'b1_0_0_0_00_10_01_0_0_0;
      7'b0010111: c = 13'b1_0_0_0_00_01_01_0_0_0;
      7'b1101111: c = 13'b1_0_0_0_00_01_10_0_1_0;
      7'b1100111: begin c = 13'b1_0_0_0_00_01_10_0_1_1; u1 = 1; end
      default: lg = 1'b0;
    endcase
  endfunction

  task automatic chk_out(input int k, input bit stl);
    string s;
    s = (k == 0) ? "lu1" : "lu3";
    chk({"ex_", s}, 32'(oex[k]), 32'({ex_m[k].v, ex_m[k].c[8:0], ex_m[k].c[10], ex_m[k].c[9],
                                      ex_m[k].c[12], ex_m[k].rd}));
    chk({"mem_", s}, 32'(omem[k]), 32'({mem_m[k].v, mem_m[k].c[10], mem_m[k].c[9],
                                        mem_m[k].c[12], mem_m[k].rd}));
    chk({"wb_", s}, 32'(owb[k]), 32'({wb_m[k].v, wb_m[k].c[12], wb_m[k].c[11], wb_m[k].rd}));
    chk({"stall_", s}, 32'(ostl[k]), 32'(stl));
    chk({"illegal_", s}, 32'(oill[k]), 32'(ill_m[k]));
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      ex_m[k] = '0; mem_m[k] = '0; wb_m[k] = '0; cnt_m[k] = 0; ill_m[k] = 1'b0;
    end
  endtask

  // Called at a negedge with inputs applied; checks, advances one edge, returns at next negedge.
  task automatic step();
    slot_t n_ex[2], n_mem[2], n_wb[2];
    int    n_cnt[2];
    bit    n_ill[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      bit frz, haz, lg, u1, u2, stl;
      bit [12:0] c;
      mdec(i_op, lg, c, u1, u2);
      frz = mem_m[k].v && (mem_m[k].c[10] || mem_m[k].c[9]) && !i_rdy;
      haz = ex_m[k].v && ex_m[k].c[10] && ex_m[k].rd != 0 && i_v &&
            ((u1 && i_rs1 == ex_m[k].rd) || (u2 && i_rs2 == ex_m[k].rd));
      stl = frz || (!i_redir && (cnt_m[k] != 0 || haz));
      chk_out(k, stl);
      if (ostl[k]) nstall[k]++;
      n_ex[k] = ex_m[k]; n_mem[k] = mem_m[k]; n_wb[k] = wb_m[k];
      n_cnt[k] = cnt_m[k]; n_ill[k] = ill_m[k];
      if (!frz) begin
        n_wb[k] = mem_m[k];
        n_mem[k] = ex_m[k];
        n_ex[k] = '0;
        if (i_redir) n_cnt[k] = 0;
        else if (cnt_m[k] != 0) n_cnt[k] = cnt_m[k] - 1;
        else if (haz) n_cnt[k] = lub[k] - 1;
        else if (i_v) begin
          if (lg) begin
            n_ex[k].v = 1'b1;
            n_ex[k].c = c;
            if (i_rd == 0) n_ex[k].c[12] = 1'b0;
            n_ex[k].rd = i_rd;
          end else if (ILL_EN) n_ill[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      ex_m[k] = n_ex[k]; mem_m[k] = n_mem[k]; wb_m[k] = n_wb[k];
      cnt_m[k] = n_cnt[k]; ill_m[k] = n_ill[k];
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                       input bit rdr, input bit rdy);
    i_v = v; i_op = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_redir = rdr; i_rdy = rdy;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      drive(0, 7'h00, 0, 0, 0, 0, 1);
      step();
    end
  endtask

  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_S = 7'b0100011;
  logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

  initial begin
    mreset();
    drive(0, 7'h00, 0, 0, 0, 0, 1);
    #1;
    for (int k = 0; k < 2; k++) chk_out(k, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load-use with a real dependency: 1 vs 3 stall cycles
    nstall = '{0, 0};
    drive(1, OP_LD, 5, 1, 0, 0, 1); step();
    for (int j = 0; j < 5; j++) begin drive(1, OP_R, 6, 1, 5, 0, 1); step(); end
    chk("lu_stalls_1", 32'(nstall[0]), 1);
    chk("lu_stalls_3", 32'(nstall[1]), 3);
    idle(3);

    // Load to x0: no stall
    nstall = '{0, 0};
    drive(1, OP_LD, 0, 1, 0, 0, 1); step();
    drive(1, OP_R, 6, 0, 0, 0, 1); step();
    chk("ld_x0_stalls_1", 32'(nstall[0]), 0);
    chk("ld_x0_stalls_3", 32'(nstall[1]), 0);
    idle(3);

    // Flush wins over hazard, counter left at zero
    nstall = '{0, 0};
    drive(1, OP_LD, 5, 1, 0, 0, 1); step();
    drive(1, OP_R, 6, 1, 5, 1, 1); step();
    chk("flush_ex_valid", 32'(b3.ex_valid), 0);
    drive(1, OP_R, 6, 1, 5, 0, 1); step();
    chk("flush_stalls_1", 32'(nstall[0]), 0);
    chk("flush_stalls_3", 32'(nstall[1]), 0);
    idle(3);

    // Freeze: store sits in MEM while memory is busy
    drive(1, OP_S, 0, 1, 2, 0, 1); step();
    idle(1);
    nstall = '{0, 0};
    for (int j = 0; j < 4; j++) begin drive(0, 7'h00, 0, 0, 0, 0, 0); step(); end
    chk("frz_stalls_1", 32'(nstall[0]), 4);
    chk("frz_stalls_3", 32'(nstall[1]), 4);
    chk("frz_mem_hold", 32'({b1.mem_valid, b1.mem_wr}), 32'b11);
    idle(1);
    chk("frz_release_wb", 32'({b1.wb_valid, b1.wb_reg_wr}), 32'b10);
    idle(2);

    // Unknown opcode becomes a bubble; flag sticky only when enabled
    drive(1, 7'b1111111, 4, 0, 0, 0, 1); step();
    chk("ill_bubble", 32'(b1.ex_valid), 0);
    chk("ill_flag", 32'(b1.illegal), 32'(ILL_EN));
    idle(2);
    chk("ill_sticky", 32'(b3.illegal), 32'(ILL_EN));

    // Randomized traffic
    for (int j = 0; j < 600; j++) begin
      logic [6:0] op;
      int sel;
      sel = $urandom_range(0, 10);
      op = (sel < 9) ? ops[sel] : 7'($urandom);
      drive($urandom_range(0, 9) < 8, op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset with a full pipe, then an R-type reaches WB in 3 edges
    for (int j = 0; j < 3; j++) begin drive(1, OP_R, 5'(j + 1), 0, 0, 0, 1); step(); end
    #2 rst_n = 1'b0;
    #1;
    mreset();
    for (int k = 0; k < 2; k++) chk_out(k, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, OP_R, 3, 1, 2, 0, 1); step();
    idle(2);
    #1;
    chk("rst_wb_lu1", 32'({b1.wb_valid, b1.wb_reg_wr, b1.wb_rd}), 32'({2'b11, 5'd3}));
    chk("rst_wb_lu3", 32'({b3.wb_valid, b3.wb_reg_wr, b3.wb_rd}), 32'({2'b11, 5'd3}));
    chk("rst_ill_clr", 32'(b1.illegal), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
